// File: rtl/fpalu_mul_result_buffer.sv
// fpalu_mul_result_buffer: classifies multiplier products, raises exception
// flags, keeps a sticky status register and buffers results in a FWFT FIFO.

// Per-result flag generation from the operand pair and the product.
module fpalu_mul_classify (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] p,
  output logic [3:0]  flags
);
  logic p_emax, p_emin, p_mzero, a_fin, b_fin, a_nz, b_nz;

  // Sign bits are ignored; only exponent and mantissa matter.
  always_comb begin
    p_emax  = (p[30:23] == 8'hFF);
    p_emin  = (p[30:23] == 8'h00);
    p_mzero = (p[22:0] == 23'd0);
    a_fin   = (a[30:23] != 8'hFF);
    b_fin   = (b[30:23] != 8'hFF);
    a_nz    = |a[30:0];
    b_nz    = |b[30:0];
    flags   = {p_emax && !p_mzero,                 // invalid: NaN
               p_emax && p_mzero && a_fin && b_fin, // overflow: Inf from finite operands
               p_emin && a_nz && b_nz,              // underflow: zero/denorm from nonzero operands
               p_emin && p_mzero};                  // zero
  end
endmodule

module fpalu_mul_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  input  logic [31:0]   in_p,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_p,
  output logic [3:0]    out_flags,
  input  logic          out_ready,
  output logic [3:0]    sticky_flags,
  input  logic          clr_sticky,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  flags;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic   [AW-1:0]    wr_ptr, rd_ptr;
  logic   [3:0]       flags_in;
  logic               push, pop;

  fpalu_mul_classify u_cls (.a(in_a), .b(in_b), .p(in_p), .flags(flags_in));

  // Handshake and FWFT head view; head is zeroed while empty.
  always_comb begin
    in_ready  = (count != CW'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_p     = out_valid ? mem[rd_ptr].p     : 32'd0;
    out_flags = out_valid ? mem[rd_ptr].flags : 4'd0;
  end

  // Storage array; contents survive reset, only pointers/count are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{p: in_p, flags: flags_in};
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracked explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky status: a push in the same cycle as a clear survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_flags <= 4'd0;
    else        sticky_flags <= (clr_sticky ? 4'd0 : sticky_flags) | (push ? flags_in : 4'd0);
  end
endmodule

// File: tb/tb_fpalu_mul_result_buffer.sv
// tb_fpalu_mul_result_buffer: scoreboard bench for the multiplier result buffer.
module tb_fpalu_mul_result_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 0, rst_n = 0;
  logic          in_valid = 0, out_ready = 0, clr_sticky = 0;
  logic [31:0]   in_a = 0, in_b = 0, in_p = 0;
  logic          in_ready, out_valid;
  logic [31:0]   out_p;
  logic [3:0]    out_flags, sticky_flags;
  logic [CW-1:0] count;

  logic [3:0]    exp_flags = 0;   // expected flags of the entry being offered
  logic [35:0]   q[$];            // scoreboard {p, flags}
  logic [3:0]    msticky = 0;
  int            checks = 0, errors = 0;

  fpalu_mul_result_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_p(in_p), .in_ready(in_ready), .out_valid(out_valid), .out_p(out_p),
    .out_flags(out_flags), .out_ready(out_ready), .sticky_flags(sticky_flags),
    .clr_sticky(clr_sticky), .count(count)
  );

  always #5 clk = ~clk;

  // Monitor: compare handshake/head/sticky against the model mid-cycle,
  // then advance the model by this cycle's handshake.
  always @(negedge clk) begin
    logic mpush, mpop;
    logic [35:0] hd;
    if (!rst_n) begin
      q.delete();
      msticky = 4'd0;
    end else begin
      checks++;
      if (in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0) || count !== CW'(q.size())) begin
        errors++;
        $display("FAIL mon_state: in_ready=%b out_valid=%b count=%0d, want occupancy %0d", in_ready, out_valid, count, q.size());
      end
      checks++;
      if (sticky_flags !== msticky) begin
        errors++;
        $display("FAIL mon_sticky: got %b want %b", sticky_flags, msticky);
      end
      mpop  = out_ready && (q.size() != 0);
      mpush = in_valid && (q.size() != DEPTH);
      if (q.size() == 0) begin
        checks++;
        if (out_p !== 32'd0 || out_flags !== 4'd0) begin
          errors++;
          $display("FAIL mon_empty_head: got p=%h f=%b want 0", out_p, out_flags);
        end
      end
      if (mpop) begin
        hd = q.pop_front();
        checks++;
        if ({out_p, out_flags} !== hd) begin
          errors++;
          $display("FAIL mon_pop: got p=%h f=%b want p=%h f=%b", out_p, out_flags, hd[35:4], hd[3:0]);
        end
      end
      msticky = (clr_sticky ? 4'd0 : msticky) | (mpush ? exp_flags : 4'd0);
      if (mpush) q.push_back({in_p, exp_flags});
    end
  end

  // Present one cycle of stimulus; returns 1 time unit after the edge.
  task automatic step(input logic v, input logic [31:0] a, b, p, input logic [3:0] ef,
                      input logic ordy, input logic clr);
    in_valid = v; in_a = a; in_b = b; in_p = p; exp_flags = ef;
    out_ready = ordy; clr_sticky = clr;
    @(posedge clk); #1;
    in_valid = 0; clr_sticky = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || count !== 0 || in_ready !== 1 || sticky_flags !== 0) begin
      errors++;
      $display("FAIL reset_initial: ov=%b cnt=%0d ir=%b st=%b want 0 0 1 0", out_valid, count, in_ready, sticky_flags);
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) step(1, 32'h3F800000, 32'h40000000, 32'h40000000 + i, 4'b0000, 0, 0);
    checks++;
    if (count !== 3) begin
      errors++;
      $display("FAIL reset_prefill: count=%0d want 3", count);
    end
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 0 || count !== 0 || in_ready !== 1 || sticky_flags !== 0 || out_p !== 0) begin
      errors++;
      $display("FAIL reset_async: ov=%b cnt=%0d ir=%b st=%b p=%h want 0 0 1 0 0", out_valid, count, in_ready, sticky_flags, out_p);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_single;
    step(1, 32'h40D00000, 32'h41400000, 32'h429C0000, 4'b0000, 0, 0);
    checks++;
    if (out_valid !== 1 || out_p !== 32'h429C0000 || out_flags !== 4'b0000 || count !== 1) begin
      errors++;
      $display("FAIL single_push: ov=%b p=%h f=%b cnt=%0d want 1 429c0000 0000 1", out_valid, out_p, out_flags, count);
    end
    step(0, 0, 0, 0, 4'b0000, 1, 0);
    checks++;
    if (out_valid !== 0 || out_p !== 32'd0) begin
      errors++;
      $display("FAIL single_pop: ov=%b p=%h want 0 0", out_valid, out_p);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h3F800000, 32'h40000000, 32'h40100000 + i, 4'b0000, 0, 0);
      if (i == 3) begin
        checks++;
        if (in_ready !== 0 || count !== 4) begin
          errors++;
          $display("FAIL full_after_4: ir=%b cnt=%0d want 0 4", in_ready, count);
        end
      end
    end
    checks++;
    if (count !== 4 || out_p !== 32'h40100000) begin
      errors++;
      $display("FAIL fifth_dropped: cnt=%0d head=%h want 4 40100000", count, out_p);
    end
    // Full: a same-cycle pop must not let a push through.
    step(1, 32'h3F800000, 32'h40000000, 32'h41000000, 4'b0000, 1, 0);
    checks++;
    if (count !== 3 || out_p !== 32'h40100001) begin
      errors++;
      $display("FAIL full_no_passthru: cnt=%0d head=%h want 3 40100001", count, out_p);
    end
    repeat (3) step(0, 0, 0, 0, 4'b0000, 1, 0);
    checks++;
    if (count !== 0 || out_valid !== 0) begin
      errors++;
      $display("FAIL drain_empty: cnt=%0d ov=%b want 0 0", count, out_valid);
    end
    // Empty push with out_ready=1 still leaves one entry, then steady push+pop.
    for (int i = 0; i < 7; i++) begin
      step(1, 32'h3F800000, 32'h40000000, 32'h40200000 + i, 4'b0000, 1, 0);
      checks++;
      if (count !== 1 || out_p !== 32'h40200000 + i) begin
        errors++;
        $display("FAIL stream_%0d: cnt=%0d head=%h want 1 %h", i, count, out_p, 32'h40200000 + i);
      end
    end
    step(0, 0, 0, 0, 4'b0000, 1, 0);
  endtask

  task automatic test_overflow;
    step(1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, 1, 0);
    checks++;
    if (out_flags !== 4'b0100 || sticky_flags[2] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: f=%b st=%b want 0100 x1xx", out_flags, sticky_flags);
    end
    step(1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, 1, 0);
    checks++;
    if (out_flags !== 4'b0000 || out_p !== 32'h7F800000) begin
      errors++;
      $display("FAIL inf_operand: f=%b p=%h want 0000 7f800000", out_flags, out_p);
    end
    step(0, 0, 0, 0, 4'b0000, 1, 0);
  endtask

  task automatic test_classify;
    logic [31:0] ta[4], tb[4], tp[4];
    logic [3:0]  tf[4];
    ta = '{32'h7F800000, 32'h00000000, 32'h0DEEEE00, 32'hC0C00000};
    tb = '{32'h00000000, 32'h41400000, 32'h0DEE0000, 32'h41400000};
    tp = '{32'h7FC00000, 32'h00000000, 32'h00000000, 32'hC2900000};
    tf = '{4'b1000, 4'b0001, 4'b0011, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      step(1, ta[i], tb[i], tp[i], tf[i], 1, 0);
      checks++;
      if (out_flags !== tf[i] || out_p !== tp[i]) begin
        errors++;
        $display("FAIL classify_%0d: f=%b p=%h want %b %h", i, out_flags, out_p, tf[i], tp[i]);
      end
    end
    step(0, 0, 0, 0, 4'b0000, 1, 0);
    checks++;
    if (sticky_flags !== 4'b1111) begin
      errors++;
      $display("FAIL sticky_accum: got %b want 1111", sticky_flags);
    end
  endtask

  task automatic test_sticky_clear;
    step(0, 0, 0, 0, 4'b0000, 1, 1);
    step(1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, 1, 0);
    checks++;
    if (sticky_flags !== 4'b0100) begin
      errors++;
      $display("FAIL sticky_set: got %b want 0100", sticky_flags);
    end
    step(1, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, 1);
    checks++;
    if (sticky_flags !== 4'b1000) begin
      errors++;
      $display("FAIL sticky_clr_push: got %b want 1000", sticky_flags);
    end
    step(0, 0, 0, 0, 4'b0000, 1, 1);
    checks++;
    if (sticky_flags !== 4'b0000 || count !== 0) begin
      errors++;
      $display("FAIL sticky_clr: st=%b cnt=%0d want 0000 0", sticky_flags, count);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_classify;
    test_sticky_clear;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
